// File: rtl/sum_pkg.sv
// Shared constants and helpers for the adder sum result buffer.
// Defaults match the 8-bit operand adder feeding this stage.
package sum_pkg;

   localparam int SUM_W          = 8;
   localparam int SUM_ACC_W      = 16;
   localparam int SUM_FIFO_DEPTH = 4;
   localparam int DROP_CNT_W     = 8;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/sum_result_buffer_if.sv
// Host-facing bundle of the sum result buffer: sample input, drain port, accumulator status.
// The master drives samples and drains results; the slave is the buffer itself.
interface sum_result_buffer_if
   import sum_pkg::*;
#(
   parameter int DATA_W = SUM_W,
   parameter int DEPTH  = SUM_FIFO_DEPTH,
   parameter int ACC_W  = SUM_ACC_W
) ();

   localparam int CNT_W = $clog2(DEPTH + 1);

   logic                  in_valid;
   logic [DATA_W-1:0]     in_data;
   logic                  in_ready;
   logic                  out_valid;
   logic [DATA_W-1:0]     out_data;
   logic                  out_ready;
   logic                  acc_clear;
   logic [ACC_W-1:0]      acc_out;
   logic                  acc_ovf;
   logic [CNT_W-1:0]      count;
   logic [DROP_CNT_W-1:0] drop_cnt;

   modport master (
      output in_valid, in_data, out_ready, acc_clear,
      input  in_ready, out_valid, out_data, acc_out, acc_ovf, count, drop_cnt
   );

   modport slave (
      input  in_valid, in_data, out_ready, acc_clear,
      output in_ready, out_valid, out_data, acc_out, acc_ovf, count, drop_cnt
   );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock register-array FIFO with valid/ready on both sides and no in->out bypass.
// A full FIFO refuses writes even when a read happens in the same cycle.
module sync_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         wr_valid,
   input  logic [DATA_W-1:0]            wr_data,
   output logic                         wr_ready,
   output logic                         rd_valid,
   output logic [DATA_W-1:0]            rd_data,
   input  logic                         rd_ready,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         push
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              pop;

   assign wr_ready = (count != CNT_W'(DEPTH));
   assign rd_valid = (count != '0);
   assign push     = wr_valid & wr_ready;
   assign pop      = rd_valid & rd_ready;
   assign rd_data  = mem[rd_ptr];

   // DEPTH is a power of two, so the pointers wrap DEPTH-1 -> 0 by overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: the storage array has no reset; only pointers and count define what is valid,
   // so clearing it would just add a reset net to every storage flop.
   always_ff @(posedge clk) begin
      if (!rst && push) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/sum_result_buffer.sv
// Buffers adder sums in a FIFO for a host and keeps a running accumulation of accepted sums,
// with a sticky carry-out flag and a saturating count of samples refused while full.
module sum_result_buffer
   import sum_pkg::*;
#(
   parameter int DATA_W = SUM_W,
   parameter int DEPTH  = SUM_FIFO_DEPTH,
   parameter int ACC_W  = SUM_ACC_W
) (
   input  logic                clk,
   input  logic                rst,
   sum_result_buffer_if.slave  bus
);

   logic                  push;
   logic [ACC_W-1:0]      acc_q;
   logic                  ovf_q;
   logic [DROP_CNT_W-1:0] drop_q;
   logic [ACC_W-1:0]      acc_base;
   logic [ACC_W:0]        acc_sum;

   sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .wr_valid (bus.in_valid),
      .wr_data  (bus.in_data),
      .wr_ready (bus.in_ready),
      .rd_valid (bus.out_valid),
      .rd_data  (bus.out_data),
      .rd_ready (bus.out_ready),
      .count    (bus.count),
      .push     (push)
   );

   // NOTE: combinational logic uses blocking '=' with a default first so no latch is inferred;
   // the registers below use non-blocking '<='.
   always_comb begin
      acc_base = acc_q;
      if (bus.acc_clear) acc_base = '0;
      // Clear-then-add: a clear in the same cycle as a push leaves just the new sample.
      acc_sum = {1'b0, acc_base} + {{(ACC_W - DATA_W + 1){1'b0}}, bus.in_data};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q  <= '0;
         ovf_q  <= 1'b0;
         drop_q <= '0;
      end else begin
         if (push) begin
            acc_q <= acc_sum[ACC_W-1:0];
            ovf_q <= (ovf_q & ~bus.acc_clear) | acc_sum[ACC_W];
         end else if (bus.acc_clear) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
         end
         if (bus.in_valid && !bus.in_ready) drop_q <= sat_inc(drop_q);
      end
   end

   assign bus.acc_out  = acc_q;
   assign bus.acc_ovf  = ovf_q;
   assign bus.drop_cnt = drop_q;

endmodule

// File: tb/tb_sum_result_buffer.sv
// Directed self-checking bench for sum_result_buffer: FIFO order, full/drop behaviour,
// accumulator wrap and clear, and mid-operation reset.
module tb_sum_result_buffer;
   import sum_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   sum_result_buffer_if #(.DATA_W(SUM_W), .DEPTH(SUM_FIFO_DEPTH), .ACC_W(SUM_ACC_W)) bus ();

   sum_result_buffer #(
      .DATA_W (SUM_W),
      .DEPTH  (SUM_FIFO_DEPTH),
      .ACC_W  (SUM_ACC_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and settle just after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [7:0] q[$];

   initial begin
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      bus.acc_clear = 1'b0;
      step();
      step();
      rst = 1'b0;
      step();

      // Reset state
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_in_ready",  32'(bus.in_ready),  32'd1);
      check("rst_count",     32'(bus.count),     32'd0);
      check("rst_acc",       32'(bus.acc_out),   32'd0);
      check("rst_ovf",       32'(bus.acc_ovf),   32'd0);
      check("rst_drop",      32'(bus.drop_cnt),  32'd0);

      // Three pushes, no pop
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h11;
      step();
      check("first_push_valid", 32'(bus.out_valid), 32'd1);
      check("first_push_count", 32'(bus.count),     32'd1);
      bus.in_data = 8'h22;
      step();
      bus.in_data = 8'h33;
      step();
      bus.in_valid = 1'b0;
      check("push3_count", 32'(bus.count),    32'd3);
      check("push3_acc",   32'(bus.acc_out),  32'h0066);
      check("push3_head",  32'(bus.out_data), 32'h11);

      // Drain in order, then one extra pop attempt on an empty FIFO
      q = '{8'h11, 8'h22, 8'h33};
      bus.out_ready = 1'b1;
      while (q.size() > 0) begin
         check("pop_order", 32'(bus.out_data), 32'(q[0]));
         void'(q.pop_front());
         step();
      end
      check("drained_valid", 32'(bus.out_valid), 32'd0);
      step();
      check("empty_pop_count", 32'(bus.count),     32'd0);
      check("empty_pop_valid", 32'(bus.out_valid), 32'd0);
      bus.out_ready = 1'b0;

      // Fill to full, then offer while popping: no pass-through, one drop
      bus.in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.in_data = 8'hA0 + 8'(i);
         step();
      end
      bus.in_data = 8'hEE;
      check("full_count",    32'(bus.count),    32'd4);
      check("full_in_ready", 32'(bus.in_ready), 32'd0);
      check("full_head",     32'(bus.out_data), 32'hA0);
      bus.out_ready = 1'b1;
      step();
      check("full_pop_count", 32'(bus.count),    32'd3);
      check("full_pop_drop",  32'(bus.drop_cnt), 32'd1);
      q = '{8'hA1, 8'hA2, 8'hA3};

      // Ten simultaneous push/pop pairs across the pointer wrap
      for (int i = 0; i < 10; i++) begin
         bus.in_data = 8'hB0 + 8'(i);
         check("wrap_order", 32'(bus.out_data), 32'(q[0]));
         void'(q.pop_front());
         q.push_back(8'hB0 + 8'(i));
         step();
      end
      bus.in_valid = 1'b0;
      check("wrap_count", 32'(bus.count), 32'd3);
      while (q.size() > 0) begin
         check("wrap_drain", 32'(bus.out_data), 32'(q[0]));
         void'(q.pop_front());
         step();
      end
      bus.out_ready = 1'b0;
      check("wrap_empty", 32'(bus.out_valid), 32'd0);

      // Saturating drop counter: 300 full cycles starting from drop_cnt=1
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hCC;
      repeat (4) step();
      check("sat_fill_drop", 32'(bus.drop_cnt), 32'd1);
      repeat (253) step();
      check("sat_drop_254", 32'(bus.drop_cnt), 32'd254);
      repeat (47) step();
      check("sat_drop_255", 32'(bus.drop_cnt), 32'd255);
      check("sat_count",    32'(bus.count),    32'd4);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      repeat (4) step();
      bus.out_ready = 1'b0;
      bus.acc_clear = 1'b1;
      step();
      bus.acc_clear = 1'b0;
      check("clear_acc", 32'(bus.acc_out), 32'd0);
      check("clear_ovf", 32'(bus.acc_ovf), 32'd0);
      check("clear_keeps_drop", 32'(bus.drop_cnt), 32'd255);

      // 0xFF streamed with continuous pop: 257*255 = 0xFFFF, 258*255 = 65790 = 0x1_00FE
      bus.in_valid  = 1'b1;
      bus.in_data   = 8'hFF;
      bus.out_ready = 1'b1;
      repeat (257) step();
      check("acc_257", 32'(bus.acc_out), 32'hFFFF);
      check("ovf_257", 32'(bus.acc_ovf), 32'd0);
      step();
      check("acc_258", 32'(bus.acc_out), 32'h00FE);
      check("ovf_258", 32'(bus.acc_ovf), 32'd1);
      check("stream_count", 32'(bus.count), 32'd1);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      step();
      check("ovf_sticky", 32'(bus.acc_ovf), 32'd1);

      // Clear together with a push: clear, then add
      bus.acc_clear = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_data   = 8'h05;
      step();
      bus.acc_clear = 1'b0;
      bus.in_valid  = 1'b0;
      check("clr_push_acc",   32'(bus.acc_out),  32'd5);
      check("clr_push_ovf",   32'(bus.acc_ovf),  32'd0);
      check("clr_push_count", 32'(bus.count),    32'd2);
      check("clr_push_drop",  32'(bus.drop_cnt), 32'd255);

      // Reset with count=2 and a push offered on the same edge
      rst          = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h77;
      step();
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      check("mid_rst_count",    32'(bus.count),     32'd0);
      check("mid_rst_valid",    32'(bus.out_valid), 32'd0);
      check("mid_rst_acc",      32'(bus.acc_out),   32'd0);
      check("mid_rst_drop",     32'(bus.drop_cnt),  32'd0);
      check("mid_rst_in_ready", 32'(bus.in_ready),  32'd1);
      step();
      check("post_rst_valid", 32'(bus.out_valid), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
